// File: rtl/freq_measure_if.sv
// Result handshake between the frequency-measurement sequencer and the display driver.
interface freq_measure_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] result_bcd;
  logic                result_valid;
  logic                result_ready;
  logic                overflow;

  modport master (output result_bcd, output result_valid, output overflow, input result_ready);
  modport slave  (input result_bcd, input result_valid, input overflow, output result_ready);
endinterface

// File: rtl/freq_measure_ctrl.sv
// Frequency-meter sequencer: fixed gate window, synchronised edge count,
// binary-to-BCD conversion and valid/ready hand-off of the result.
module freq_measure_ctrl #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 27,
  parameter int DIGITS      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           sig_in,
  freq_measure_if.master res,
  output logic           busy,
  output logic           gate_led
);
  localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int CW = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam int BW = 4 * DIGITS;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(10**DIGITS - 1);

  typedef enum logic [1:0] {IDLE, GATE, CONVERT, PUBLISH} state_t;

  state_t           state, state_nxt;
  logic             s1, s2, s3, edge_p;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             cnt_sat, ovf_cnt;
  logic [CW-1:0]    conv_idx;
  logic [CNT_W-1:0] bin_sr;
  logic [BW-1:0]    bcd_sr, bcd_adj;
  logic             gate_last, conv_last, accept, gate_start, conv_start;

  always_comb begin
    edge_p    = s2 & ~s3;
    gate_last = (timer == TW'(GATE_CYCLES - 1));
    conv_last = (conv_idx == CW'(CNT_W - 1));
    accept    = res.result_valid & res.result_ready;
    cnt_sat   = (cnt == CNT_MAX);
    // The final gate cycle's edge must reach the converter, so load from the next count.
    cnt_nxt   = (edge_p && !cnt_sat) ? cnt + 1'b1 : cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = GATE;
      GATE:    if (!en) state_nxt = IDLE;
               else if (gate_last) state_nxt = CONVERT;
      CONVERT: if (conv_last) state_nxt = PUBLISH;
      PUBLISH: if (accept) state_nxt = en ? GATE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    gate_start = (state != GATE) && (state_nxt == GATE);
    conv_start = (state == GATE) && (state_nxt == CONVERT);
  end

  always_comb begin
    bcd_adj = bcd_sr;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (bcd_sr[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer    <= '0;
      cnt      <= '0;
      ovf_cnt  <= 1'b0;
      gate_led <= 1'b0;
    end else if (gate_start) begin
      timer    <= '0;
      cnt      <= '0;
      ovf_cnt  <= 1'b0;
      gate_led <= ~gate_led;
    end else if (state == GATE) begin
      timer <= timer + 1'b1;
      cnt   <= cnt_nxt;
      if (edge_p && cnt_sat) ovf_cnt <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sr   <= '0;
      bcd_sr   <= '0;
      conv_idx <= '0;
    end else if (conv_start) begin
      bin_sr   <= cnt_nxt;
      bcd_sr   <= '0;
      conv_idx <= '0;
    end else if (state == CONVERT) begin
      {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
      conv_idx         <= conv_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res.result_bcd   <= '0;
      res.result_valid <= 1'b0;
      res.overflow     <= 1'b0;
    end else if (state == PUBLISH) begin
      if (!res.result_valid) begin
        res.result_bcd   <= bcd_sr;
        res.overflow     <= ovf_cnt;
        res.result_valid <= 1'b1;
      end else if (res.result_ready) begin
        res.result_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_freq_measure_ctrl.sv
// Self-checking bench for freq_measure_ctrl: table vectors, random periods against
// an edge-counting reference, and hand-written stall/abort/reset sequences.
module tb_freq_measure_ctrl;
  localparam int G = 1000;

  logic clk = 1'b0, rst_n = 1'b0, sig_in = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0, rdy_a = 1'b0, rdy_b = 1'b0;
  logic busy_a, busy_b, led_a, led_b;
  logic sel_b = 1'b0;
  logic exp_led_a = 1'b0, exp_led_b = 1'b0;
  logic [31:0] cur_bcd;
  logic cur_valid, cur_ovf, cur_busy, cur_led;
  int cyc = 0;
  int total = 0, bad = 0;
  int pat_per = 10, pat_hi = 0, pat_ph = 0;

  freq_measure_if #(.DIGITS(8)) if_a ();
  freq_measure_if #(.DIGITS(2)) if_b ();

  assign if_a.result_ready = rdy_a;
  assign if_b.result_ready = rdy_b;

  freq_measure_ctrl #(.GATE_CYCLES(G), .CNT_W(27), .DIGITS(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .sig_in(sig_in),
    .res(if_a.master), .busy(busy_a), .gate_led(led_a));

  freq_measure_ctrl #(.GATE_CYCLES(G), .CNT_W(7), .DIGITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .sig_in(sig_in),
    .res(if_b.master), .busy(busy_b), .gate_led(led_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    if (sel_b) begin
      cur_bcd   = {24'h0, if_b.result_bcd};
      cur_valid = if_b.result_valid;
      cur_ovf   = if_b.overflow;
      cur_busy  = busy_b;
      cur_led   = led_b;
    end else begin
      cur_bcd   = if_a.result_bcd;
      cur_valid = if_a.result_valid;
      cur_ovf   = if_a.overflow;
      cur_busy  = busy_a;
      cur_led   = led_a;
    end
  end

  // Level of sig_in sampled at posedge n for the current pattern.
  function automatic logic wave(input int n, input int per, input int hi, input int ph);
    if (hi <= 0) return 1'b0;
    return ((n + ph) % per) < hi;
  endfunction

  initial forever begin
    @(negedge clk);
    sig_in = wave(cyc + 1, pat_per, pat_hi, pat_ph);
  end

  // Rising edges whose sample lands in the window counted by a gate entered at posedge e.
  function automatic int model_count(input int per, input int hi, input int ph, input int e);
    int n = 0;
    for (int k = e - 1; k <= e + G - 2; k++)
      if (wave(k, per, hi, ph) && !wave(k - 1, per, hi, ph)) n++;
    return n;
  endfunction

  function automatic void to_bcd(input int n_in, input int digits,
                                 output logic [31:0] b, output logic o);
    int mx = 1;
    int n = n_in;
    for (int d = 0; d < digits; d++) mx = mx * 10;
    mx = mx - 1;
    o = (n > mx);
    if (o) n = mx;
    b = '0;
    for (int d = 0; d < digits; d++) begin
      b[4*d +: 4] = 4'(n % 10);
      n = n / 10;
    end
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_ctl(input logic sb, input logic en_v, input logic rdy_v);
    if (sb) begin en_b = en_v; rdy_b = rdy_v; end
    else    begin en_a = en_v; rdy_a = rdy_v; end
  endtask

  task automatic wait_valid();
    int t = 0;
    while (cur_valid !== 1'b1 && t < G + 100) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic run_meas(input logic sb, input int per, input int hi, input int ph,
                          output logic [31:0] bcd, output logic ovf, output int e);
    int cw = sb ? 7 : 27;
    sel_b = sb;
    pat_per = per; pat_hi = hi; pat_ph = ph;
    repeat (4) @(negedge clk);
    chk("idle_valid", cur_valid, 1'b0);
    set_ctl(sb, 1'b1, 1'b0);
    if (sb) exp_led_b = ~exp_led_b; else exp_led_a = ~exp_led_a;
    e = cyc + 1;
    wait_valid();
    chk("valid_rise", cur_valid, 1'b1);
    chk("latency", cyc, e + G + cw + 1);
    chk("busy_pub", cur_busy, 1'b1);
    chk("gate_led", cur_led, sb ? exp_led_b : exp_led_a);
    bcd = cur_bcd;
    ovf = cur_ovf;
    set_ctl(sb, 1'b0, 1'b1);
    @(negedge clk);
    chk("valid_drop", cur_valid, 1'b0);
    chk("idle_busy", cur_busy, 1'b0);
    chk("bcd_held", cur_bcd, bcd);
    set_ctl(sb, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic        sb;
    int          per;
    int          hi;
    int          ph;
    logic [31:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  initial begin
    vec_t tbl[7];
    logic [31:0] got, eb, held;
    logic go, eo, stable, led0;
    int e, n;

    tbl[0] = '{1'b0, 10, 5, 0, 32'h0000_0100, 1'b0};
    tbl[1] = '{1'b0, 10, 0, 0, 32'h0000_0000, 1'b0};
    tbl[2] = '{1'b0,  4, 2, 1, 32'h0000_0250, 1'b0};
    tbl[3] = '{1'b1,  4, 2, 0, 32'h0000_0099, 1'b1};
    tbl[4] = '{1'b1, 20, 10, 3, 32'h0000_0050, 1'b0};
    tbl[5] = '{1'b0,  8, 4, 5, 32'h0000_0125, 1'b0};
    tbl[6] = '{1'b1, 10, 5, 7, 32'h0000_0099, 1'b1};

    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel_b = (s == 1);
      #1;
      chk("rst_bcd", cur_bcd, 32'h0);
      chk("rst_valid", cur_valid, 1'b0);
      chk("rst_ovf", cur_ovf, 1'b0);
      chk("rst_busy", cur_busy, 1'b0);
      chk("rst_led", cur_led, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_meas(tbl[i].sb, tbl[i].per, tbl[i].hi, tbl[i].ph, got, go, e);
      chk("tbl_bcd", got, tbl[i].exp_bcd);
      chk("tbl_ovf", go, tbl[i].exp_ovf);
    end

    for (int r = 0; r < 8; r++) begin
      logic sb = 1'($urandom_range(0, 1));
      int per = int'($urandom_range(4, 40));
      int hi  = int'($urandom_range(2, per - 2));
      int ph  = int'($urandom_range(0, per - 1));
      run_meas(sb, per, hi, ph, got, go, e);
      n = model_count(per, hi, ph, e);
      to_bcd(n, sb ? 2 : 8, eb, eo);
      chk("rnd_bcd", got, eb);
      chk("rnd_ovf", go, eo);
    end

    // Back-pressure: result held while ready is low, then straight into the next gate.
    sel_b = 1'b0;
    pat_per = 10; pat_hi = 5; pat_ph = 2;
    repeat (4) @(negedge clk);
    en_a = 1'b1; rdy_a = 1'b0;
    exp_led_a = ~exp_led_a;
    wait_valid();
    chk("stall_valid", cur_valid, 1'b1);
    chk("stall_bcd", cur_bcd, 32'h0000_0100);
    held = cur_bcd;
    led0 = cur_led;
    stable = 1'b1;
    repeat (500) begin
      @(negedge clk);
      if (cur_valid !== 1'b1 || cur_bcd !== held || cur_led !== led0 || cur_busy !== 1'b1)
        stable = 1'b0;
    end
    chk("stall_stable", stable, 1'b1);
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    exp_led_a = ~exp_led_a;
    chk("accept_drop", cur_valid, 1'b0);
    chk("regate_led", cur_led, exp_led_a);
    chk("regate_busy", cur_busy, 1'b1);

    // Abort at gate cycle 400.
    repeat (399) @(negedge clk);
    en_a = 1'b0;
    @(negedge clk);
    chk("abort_busy", cur_busy, 1'b0);
    chk("abort_valid", cur_valid, 1'b0);
    stable = 1'b1;
    repeat (1100) begin
      @(negedge clk);
      if (cur_valid !== 1'b0 || cur_bcd !== held || cur_busy !== 1'b0) stable = 1'b0;
    end
    chk("abort_quiet", stable, 1'b1);
    chk("abort_led", cur_led, exp_led_a);

    // Reset in the middle of conversion.
    en_a = 1'b1;
    exp_led_a = ~exp_led_a;
    e = cyc + 1;
    repeat (G + 10) @(negedge clk);
    chk("pre_rst_busy", cur_busy, 1'b1);
    rst_n = 1'b0;
    en_a = 1'b0;
    #1;
    chk("mid_rst_bcd", cur_bcd, 32'h0);
    chk("mid_rst_valid", cur_valid, 1'b0);
    chk("mid_rst_ovf", cur_ovf, 1'b0);
    chk("mid_rst_busy", cur_busy, 1'b0);
    chk("mid_rst_led", cur_led, 1'b0);
    exp_led_a = 1'b0;
    exp_led_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_meas(1'b0, 10, 5, 4, got, go, e);
    chk("post_rst_bcd", got, 32'h0000_0100);
    chk("post_rst_ovf", go, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
